// File: rtl/aec_expr_loader_pkg.sv
// Shared definitions for the AEC expression loader and the calculator front end.
package aec_pkg;

  // ASCII codes of the characters the calculator understands
  localparam logic [7:0] ChLParen = 8'h28;
  localparam logic [7:0] ChRParen = 8'h29;
  localparam logic [7:0] ChStar   = 8'h2A;
  localparam logic [7:0] ChPlus   = 8'h2B;
  localparam logic [7:0] ChMinus  = 8'h2D;
  localparam logic [7:0] ChZero   = 8'h30;
  localparam logic [7:0] ChNine   = 8'h39;
  localparam logic [7:0] ChEq     = 8'h3D;
  localparam logic [7:0] ChLowA   = 8'h61;
  localparam logic [7:0] ChLowF   = 8'h66;

  typedef enum logic [1:0] {
    StCollect = 2'd0,
    StIssue   = 2'd1,
    StWaitRes = 2'd2,
    StDrop    = 2'd3
  } state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_PAREN   = 3'd3;
  localparam logic [2:0] ERR_EMPTY   = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;

endpackage

// File: rtl/aec_expr_loader_if.sv
// Host byte stream, calculator burst and error reporting signals of the loader.
interface aec_expr_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] ascii_out;
  logic       aec_ready;
  logic       aec_valid;
  logic       err;
  logic [2:0] err_code;

  // Environment side: host plus calculator
  modport master (
    output in_valid, in_data, aec_valid,
    input  in_ready, ascii_out, aec_ready, err, err_code
  );

  // Loader side
  modport slave (
    input  in_valid, in_data, aec_valid,
    output in_ready, ascii_out, aec_ready, err, err_code
  );
endinterface

// File: rtl/aec_expr_loader_char_class.sv
// Combinational classifier for one ASCII byte of an AEC expression.
module aec_char_class
  import aec_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_legal_o,
  output logic       is_lparen_o,
  output logic       is_rparen_o,
  output logic       is_eq_o
);

  logic is_digit, is_hex_alpha, is_op;

  // Decode digit, hex letter and operator groups, then combine
  always_comb begin
    is_digit     = (char_i >= ChZero) && (char_i <= ChNine);
    is_hex_alpha = (char_i >= ChLowA) && (char_i <= ChLowF);
    is_op        = (char_i == ChStar) || (char_i == ChPlus) || (char_i == ChMinus);
    is_lparen_o  = (char_i == ChLParen);
    is_rparen_o  = (char_i == ChRParen);
    is_eq_o      = (char_i == ChEq);
    is_legal_o   = is_digit || is_hex_alpha || is_op || is_lparen_o || is_rparen_o || is_eq_o;
  end

endmodule

// File: rtl/aec_expr_loader.sv
// Buffers one '='-terminated expression, screens it, and replays it to the calculator.
module aec_expr_loader
  import aec_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned MAX_DEPTH = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input logic              clk,
  input logic              rst,
  aec_expr_loader_if.slave bus
);

  localparam int unsigned LenW  = $clog2(MAX_LEN) + 1;
  localparam int unsigned AddrW = $clog2(MAX_LEN);

  state_e          state_q, state_d;
  logic [LenW-1:0] len_q, len_d;
  logic [LenW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]      depth_q, depth_d;
  logic [7:0]      timer_q, timer_d;
  logic            err_q, err_d;
  logic [2:0]      err_code_q, err_code_d;
  logic [7:0]      buf_q [MAX_LEN];
  logic            wr_en;

  logic       in_ready, aec_ready;
  logic [7:0] ascii_out;
  logic       xfer;
  logic       is_legal, is_lparen, is_rparen, is_eq;

  aec_char_class u_char_class (
    .char_i      (bus.in_data),
    .is_legal_o  (is_legal),
    .is_lparen_o (is_lparen),
    .is_rparen_o (is_rparen),
    .is_eq_o     (is_eq)
  );

  assign xfer = bus.in_valid && in_ready;

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StCollect;
      len_q      <= '0;
      rd_ptr_q   <= '0;
      depth_q    <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_ptr_q   <= rd_ptr_d;
      depth_q    <= depth_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Expression buffer; contents are only meaningful below len_q
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[len_q[AddrW-1:0]] <= bus.in_data;
    end
  end

  // Next state: screening while collecting, burst sequencing and result wait
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_ptr_d   = rd_ptr_q;
    depth_d    = depth_q;
    timer_d    = timer_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    wr_en      = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (xfer) begin
          if (!is_legal) begin
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL;
            state_d    = StDrop;
          end else if (!is_eq && (len_q == LenW'(MAX_LEN - 1))) begin
            // Last slot is reserved for the terminating '='
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = StDrop;
          end else if ((is_lparen && (depth_q == 2'(MAX_DEPTH))) ||
                       (is_rparen && (depth_q == 2'd0)) ||
                       (is_eq && (depth_q != 2'd0))) begin
            err_d      = 1'b1;
            err_code_d = ERR_PAREN;
            state_d    = StDrop;
          end else if (is_eq && (len_q == '0)) begin
            // Empty expression: nothing to drop, keep collecting
            err_d      = 1'b1;
            err_code_d = ERR_EMPTY;
          end else begin
            wr_en = 1'b1;
            len_d = len_q + LenW'(1);
            if (is_lparen) begin
              depth_d = depth_q + 2'd1;
            end else if (is_rparen) begin
              depth_d = depth_q - 2'd1;
            end
            if (is_eq) begin
              state_d  = StIssue;
              rd_ptr_d = '0;
            end
          end
        end
      end
      StDrop: begin
        if (xfer && is_eq) begin
          state_d = StCollect;
          len_d   = '0;
          depth_d = '0;
        end
      end
      StIssue: begin
        if (rd_ptr_q == (len_q - LenW'(1))) begin
          state_d = StWaitRes;
          timer_d = '0;
        end else begin
          rd_ptr_d = rd_ptr_q + LenW'(1);
        end
      end
      StWaitRes: begin
        if (bus.aec_valid) begin
          state_d = StCollect;
          len_d   = '0;
          depth_d = '0;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          timer_d    = timer_q + 8'd1;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = StCollect;
          len_d      = '0;
          depth_d    = '0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  // Outputs decoded from state so an asynchronous reset drops them at once
  always_comb begin
    in_ready  = 1'b0;
    aec_ready = 1'b0;
    ascii_out = 8'h00;
    case (state_q)
      StCollect, StDrop: in_ready = 1'b1;
      StIssue: begin
        aec_ready = 1'b1;
        ascii_out = buf_q[rd_ptr_q[AddrW-1:0]];
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.aec_ready = aec_ready;
  assign bus.ascii_out = ascii_out;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;

endmodule
